// File: rtl/system_0_sysid_checker.sv
// system_0_sysid_checker
//
// Boot-time integrity monitor for system_0. Acts as an Avalon-MM initiator
// that reads the system ID peripheral: word 0 (system ID) first, then word 1
// (build timestamp). It compares both words against build-time expected values
// so firmware or an LED can flag a hardware/software image mismatch.
//
// Optional feature macro: SYSID_CHECK_TIMEOUT_EN
//   defined     - a read is abandoned after TIMEOUT_CYCLES consecutive
//                 waitrequest-high clocks, and timeout_err reports it
//   not defined - no timeout counter; reads wait indefinitely on waitrequest,
//                 and timeout_err is tied low
//
// Parameters:
//   EXPECTED_ID         value required at word address 0
//   EXPECTED_TIMESTAMP  value required at word address 1
//   READ_LATENCY        fixed slave read latency in clocks (0..3)
//   TIMEOUT_CYCLES      max consecutive stall clocks per read (1..255)
//   AUTO_START          run one check automatically after reset release
//
// Ports:
//   clock            system clock
//   reset_n          asynchronous active-low reset
//   start            one-clock pulse; starts a check when idle or done
//   avm_address      word address to slave (0 = ID, 1 = timestamp), registered
//   avm_read         read request, registered
//   avm_readdata     slave read data
//   avm_waitrequest  slave stall
//   id_value         captured word 0
//   timestamp_value  captured word 1
//   busy             check in progress
//   done             check finished; held until the next start
//   match            both words equal expected; valid while done=1
//   timeout_err      a read exceeded TIMEOUT_CYCLES; valid while done=1

module system_0_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1763563818,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Reject out-of-range configurations at elaboration time.
    if (READ_LATENCY < 0 || READ_LATENCY > 3 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("system_0_sysid_checker: READ_LATENCY must be 0..3, TIMEOUT_CYCLES 1..255");
    end

    localparam bit         ZERO_LATENCY = (READ_LATENCY == 0);
    // Last latency count value; the data is captured on that clock.
    localparam logic [1:0] LAT_LAST     = ZERO_LATENCY ? 2'd0 : 2'(READ_LATENCY - 1);

    state_t     state;
    state_t     next_state;
    logic       auto_pending;
    logic [1:0] lat_cnt;

    logic       in_read;
    logic       in_latency;
    logic       accept;
    logic       lat_last;
    logic       timeout_hit;
    logic       capture_id;
    logic       capture_ts;
    logic       words_ok;
    logic       finishing;

    assign in_read    = (state == RD_ID) || (state == RD_TS);
    assign in_latency = (state == LAT_ID) || (state == LAT_TS);
    assign accept     = in_read && !avm_waitrequest;
    assign lat_last   = (lat_cnt == LAT_LAST);
    assign words_ok   = (id_value == EXPECTED_ID) &&
                        (timestamp_value == EXPECTED_TIMESTAMP);

`ifdef SYSID_CHECK_TIMEOUT_EN
    // The timeout fires on the stall clock that brings the count to
    // TIMEOUT_CYCLES, so avm_read is high for exactly TIMEOUT_CYCLES
    // stalled clocks before it drops.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;

    assign timeout_hit = in_read && avm_waitrequest && (wait_cnt == WAIT_LAST);

    // Consecutive stall counter; any accept or state change restarts it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if (in_read && avm_waitrequest && (next_state == state)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Sticky until the next check is launched out of DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if ((state == DONE) && (next_state == RD_ID)) begin
            timeout_err <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic. A timeout takes priority over an accept in the same
    // clock; start is only honoured in IDLE and DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start || auto_pending) begin
                    next_state = RD_ID;
                end
            end
            RD_ID: begin
                if (timeout_hit) begin
                    next_state = DONE;
                end else if (accept) begin
                    next_state = ZERO_LATENCY ? RD_TS : LAT_ID;
                end
            end
            LAT_ID: begin
                if (lat_last) begin
                    next_state = RD_TS;
                end
            end
            RD_TS: begin
                if (timeout_hit) begin
                    next_state = DONE;
                end else if (accept) begin
                    next_state = ZERO_LATENCY ? DONE : LAT_TS;
                end
            end
            LAT_TS: begin
                if (lat_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = RD_ID;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Data is valid in the accept clock for zero latency, otherwise on the
    // last latency clock.
    always_comb begin
        capture_id = 1'b0;
        capture_ts = 1'b0;
        if (ZERO_LATENCY) begin
            capture_id = (state == RD_ID) && accept && !timeout_hit;
            capture_ts = (state == RD_TS) && accept && !timeout_hit;
        end else begin
            capture_id = (state == LAT_ID) && lat_last;
            capture_ts = (state == LAT_TS) && lat_last;
        end
    end

    // done/match are set on the clock after DONE is entered so that match is
    // computed from the already-captured timestamp register.
    assign finishing = (state == DONE) && (next_state == DONE);

    // State register and all registered outputs. Bus outputs are derived from
    // next_state so they line up with the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            auto_pending    <= AUTO_START;
            lat_cnt         <= 2'd0;
            avm_read        <= 1'b0;
            avm_address     <= 1'b0;
            id_value        <= 32'd0;
            timestamp_value <= 32'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            match           <= 1'b0;
        end else begin
            state        <= next_state;
            auto_pending <= 1'b0;

            if (in_latency && !lat_last) begin
                lat_cnt <= lat_cnt + 2'd1;
            end else begin
                lat_cnt <= 2'd0;
            end

            avm_read    <= (next_state == RD_ID) || (next_state == RD_TS);
            avm_address <= (next_state == RD_TS) || (next_state == LAT_TS);

            // Busy covers the whole read sequence plus the first DONE clock,
            // dropping on the same edge that raises done.
            busy <= ((next_state != IDLE) && (next_state != DONE)) ||
                    ((next_state == DONE) && (state != DONE));

            done  <= finishing;
            match <= finishing && words_ok && !timeout_err;

            if (capture_id) begin
                id_value <= avm_readdata;
            end
            if (capture_ts) begin
                timestamp_value <= avm_readdata;
            end
        end
    end

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// tb_system_0_sysid_checker
//
// Directed bench for system_0_sysid_checker. Three instances share clock,
// reset and the slave word contents:
//   dut_a  zero latency, default timeout, combinational slave
//   dut_b  READ_LATENCY=2, slave returns data two clocks after accept
//   dut_c  TIMEOUT_CYCLES=4, used for the stuck-waitrequest case
// Inputs change and outputs are sampled on the falling clock edge.

module tb_system_0_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1763563818;

    logic        clock;
    logic        reset_n;
    logic [31:0] mem_id;
    logic [31:0] mem_ts;

    int checks;
    int errors;

    logic        a_start, a_wait, a_addr, a_read, a_busy, a_done, a_match, a_terr;
    logic [31:0] a_rdata, a_id, a_ts;
    logic        b_start, b_wait, b_addr, b_read, b_busy, b_done, b_match, b_terr;
    logic [31:0] b_rdata, b_id, b_ts;
    logic        c_start, c_wait, c_addr, c_read, c_busy, c_done, c_match, c_terr;
    logic [31:0] c_rdata, c_id, c_ts;

    logic        pipe1_v, pipe1_a, pipe2_v, pipe2_a;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Zero-latency slaves: data follows the address combinationally.
    assign a_rdata = a_addr ? mem_ts : mem_id;
    assign c_rdata = c_addr ? mem_ts : mem_id;

    // Two-clock latency slave; outside the valid slot it returns junk so a
    // capture in the wrong clock is visible.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe1_v <= 1'b0;
            pipe1_a <= 1'b0;
            pipe2_v <= 1'b0;
            pipe2_a <= 1'b0;
        end else begin
            pipe1_v <= b_read && !b_wait;
            pipe1_a <= b_addr;
            pipe2_v <= pipe1_v;
            pipe2_a <= pipe1_a;
        end
    end
    assign b_rdata = pipe2_v ? (pipe2_a ? mem_ts : mem_id) : 32'hDEAD_BEEF;

    system_0_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
        .READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .start(a_start),
        .avm_address(a_addr), .avm_read(a_read), .avm_readdata(a_rdata),
        .avm_waitrequest(a_wait), .id_value(a_id), .timestamp_value(a_ts),
        .busy(a_busy), .done(a_done), .match(a_match), .timeout_err(a_terr)
    );

    system_0_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
        .READ_LATENCY(2), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .start(b_start),
        .avm_address(b_addr), .avm_read(b_read), .avm_readdata(b_rdata),
        .avm_waitrequest(b_wait), .id_value(b_id), .timestamp_value(b_ts),
        .busy(b_busy), .done(b_done), .match(b_match), .timeout_err(b_terr)
    );

    system_0_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
        .READ_LATENCY(0), .TIMEOUT_CYCLES(4), .AUTO_START(1'b1)
    ) dut_c (
        .clock(clock), .reset_n(reset_n), .start(c_start),
        .avm_address(c_addr), .avm_read(c_read), .avm_readdata(c_rdata),
        .avm_waitrequest(c_wait), .id_value(c_id), .timestamp_value(c_ts),
        .busy(c_busy), .done(c_done), .match(c_match), .timeout_err(c_terr)
    );

    // One-clock start pulse to the selected instance (0=a, 1=b, 2=c).
    // Returns on the falling edge after the edge that sampled start.
    task automatic applyStimulus(input int unit);
        a_start = (unit == 0);
        b_start = (unit == 1);
        c_start = (unit == 2);
        @(negedge clock);
        a_start = 1'b0;
        b_start = 1'b0;
        c_start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        c_start = 1'b0;
        a_wait  = 1'b0;
        b_wait  = 1'b0;
        c_wait  = 1'b0;
        mem_id  = 32'd0;
        mem_ts  = EXP_TS;

        // Reset values
        repeat (2) @(negedge clock);
        checkOutput("rst_read", a_read, 1'b0);
        checkOutput("rst_addr", a_addr, 1'b0);
        checkOutput("rst_id", a_id, 32'd0);
        checkOutput("rst_ts", a_ts, 32'd0);
        checkOutput("rst_busy", a_busy, 1'b0);
        checkOutput("rst_done", a_done, 1'b0);
        checkOutput("rst_match", a_match, 1'b0);
        checkOutput("rst_terr", a_terr, 1'b0);

        // Auto-start after release, best-case timing
        $display("[TB] auto-start check");
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("auto_rd0_read", a_read, 1'b1);
        checkOutput("auto_rd0_addr", a_addr, 1'b0);
        checkOutput("auto_busy", a_busy, 1'b1);
        @(negedge clock);
        checkOutput("auto_rd1_read", a_read, 1'b1);
        checkOutput("auto_rd1_addr", a_addr, 1'b1);
        checkOutput("auto_id", a_id, EXP_ID);
        @(negedge clock);
        checkOutput("auto_idle_read", a_read, 1'b0);
        checkOutput("auto_not_done_yet", a_done, 1'b0);
        checkOutput("auto_ts", a_ts, EXP_TS);
        @(negedge clock);
        checkOutput("auto_done", a_done, 1'b1);
        checkOutput("auto_match", a_match, 1'b1);
        checkOutput("auto_busy_off", a_busy, 1'b0);
        checkOutput("auto_terr", a_terr, 1'b0);

        // Wrong ID word
        $display("[TB] id mismatch");
        mem_id = 32'h0000_0001;
        applyStimulus(0);
        checkOutput("mis_done_cleared", a_done, 1'b0);
        checkOutput("mis_read", a_read, 1'b1);
        checkOutput("mis_busy", a_busy, 1'b1);
        repeat (3) @(negedge clock);
        checkOutput("mis_done", a_done, 1'b1);
        checkOutput("mis_match", a_match, 1'b0);
        checkOutput("mis_id", a_id, 32'h0000_0001);
        // Latency-2 instance finished its auto-start run by now
        checkOutput("lat_auto_done", b_done, 1'b1);
        checkOutput("lat_auto_match", b_match, 1'b1);
        checkOutput("lat_auto_ts", b_ts, EXP_TS);

        // Five stall clocks on the timestamp read
        $display("[TB] waitrequest stall");
        mem_id = 32'd0;
        applyStimulus(0);
        @(negedge clock);
        checkOutput("stall_addr_start", a_addr, 1'b1);
        a_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput($sformatf("stall_read_%0d", i), a_read, 1'b1);
            checkOutput($sformatf("stall_addr_%0d", i), a_addr, 1'b1);
        end
        a_wait = 1'b0;
        @(negedge clock);
        checkOutput("stall_read_drop", a_read, 1'b0);
        checkOutput("stall_done_early", a_done, 1'b0);
        @(negedge clock);
        checkOutput("stall_done", a_done, 1'b1);
        checkOutput("stall_match", a_match, 1'b1);

        // Read latency 2
        $display("[TB] read latency 2");
        mem_id = 32'd5;
        applyStimulus(1);
        checkOutput("lat_rd0_read", b_read, 1'b1);
        checkOutput("lat_rd0_addr", b_addr, 1'b0);
        @(negedge clock);
        checkOutput("lat_gap0_read", b_read, 1'b0);
        @(negedge clock);
        checkOutput("lat_gap1_read", b_read, 1'b0);
        @(negedge clock);
        checkOutput("lat_rd1_read", b_read, 1'b1);
        checkOutput("lat_rd1_addr", b_addr, 1'b1);
        checkOutput("lat_id", b_id, 32'd5);
        repeat (3) @(negedge clock);
        checkOutput("lat_ts", b_ts, EXP_TS);
        checkOutput("lat_busy", b_busy, 1'b1);
        checkOutput("lat_not_done", b_done, 1'b0);
        @(negedge clock);
        checkOutput("lat_done", b_done, 1'b1);
        checkOutput("lat_match_bad", b_match, 1'b0);
        mem_id = 32'd0;
        applyStimulus(1);
        repeat (7) @(negedge clock);
        checkOutput("lat2_done", b_done, 1'b1);
        checkOutput("lat2_match", b_match, 1'b1);
        checkOutput("lat2_id", b_id, 32'd0);

        // Stuck waitrequest
`ifdef SYSID_CHECK_TIMEOUT_EN
        $display("[TB] timeout");
        c_wait = 1'b1;
        applyStimulus(2);
        checkOutput("to_read_0", c_read, 1'b1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            checkOutput($sformatf("to_read_%0d", i), c_read, 1'b1);
        end
        @(negedge clock);
        checkOutput("to_read_drop", c_read, 1'b0);
        @(negedge clock);
        checkOutput("to_done", c_done, 1'b1);
        checkOutput("to_terr", c_terr, 1'b1);
        checkOutput("to_match", c_match, 1'b0);
        checkOutput("to_busy", c_busy, 1'b0);
        c_wait = 1'b0;
        applyStimulus(2);
        checkOutput("to_terr_cleared", c_terr, 1'b0);
        checkOutput("to_done_cleared", c_done, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("to_retry_done", c_done, 1'b1);
        checkOutput("to_retry_match", c_match, 1'b1);
        checkOutput("to_retry_terr", c_terr, 1'b0);
`else
        $display("[TB] stall without timeout");
        c_wait = 1'b1;
        applyStimulus(2);
        repeat (10) @(negedge clock);
        checkOutput("nto_read", c_read, 1'b1);
        checkOutput("nto_busy", c_busy, 1'b1);
        checkOutput("nto_terr", c_terr, 1'b0);
        c_wait = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("nto_done", c_done, 1'b1);
        checkOutput("nto_match", c_match, 1'b1);
        checkOutput("nto_terr_done", c_terr, 1'b0);
`endif

        // Reset during the timestamp read
        $display("[TB] reset mid-read");
        mem_id = 32'd7;
        applyStimulus(0);
        @(negedge clock);
        a_wait = 1'b1;
        @(negedge clock);
        checkOutput("mid_read_active", a_read, 1'b1);
        checkOutput("mid_id_captured", a_id, 32'd7);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_read", a_read, 1'b0);
        checkOutput("mid_rst_addr", a_addr, 1'b0);
        checkOutput("mid_rst_busy", a_busy, 1'b0);
        checkOutput("mid_rst_done", a_done, 1'b0);
        checkOutput("mid_rst_id", a_id, 32'd0);
        checkOutput("mid_rst_ts", a_ts, 32'd0);
        checkOutput("mid_rst_match", a_match, 1'b0);
        @(negedge clock);
        a_wait  = 1'b0;
        mem_id  = 32'd0;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("post_rst_done", a_done, 1'b1);
        checkOutput("post_rst_match", a_match, 1'b1);
        checkOutput("post_rst_ts", a_ts, EXP_TS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
